// File: rtl/alu_vector_checker.sv
// ALU self-test engine: fetches {op,a,b,exp} vectors from a sync ROM, drives the ALU, checks result/zero.
// Per-vector cost ALU_LAT+3 cycles; start is only accepted in IDLE/DONE, ignored while busy.
module alu_vector_checker #(
    parameter int DW      = 32,
    parameter int OPW     = 4,
    parameter int AW      = 4,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       num_vec,
    output logic [AW-1:0]     vec_addr,
    input  logic [OPW+3*DW-1:0] vec_data,
    output logic [OPW-1:0]    alu_op,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    input  logic [DW-1:0]     alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW:0]       vec_cnt,
    output logic [AW:0]       err_cnt,
    output logic              err_valid,
    output logic [AW-1:0]     err_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_CHECK, S_DONE
    } state_t;

    localparam int            LW        = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LW-1:0] WAIT_INIT = LW'(ALU_LAT - 1);
    localparam logic [AW:0]   MAX_VEC   = {1'b1, {AW{1'b0}}};

    state_t          state, state_nxt;
    logic [AW-1:0]   idx;
    logic [AW:0]     num_lim;
    logic [LW-1:0]   wait_cnt;
    logic [DW-1:0]   exp_q;
    logic [AW+1:0]   vec_inc;
    logic            more_vec;
    logic            exp_zero;
    logic            mismatch;

    // Decision uses the pre-increment count so the last CHECK routes to DONE.
    assign vec_inc  = {1'b0, vec_cnt} + (AW+2)'(1);
    assign more_vec = vec_inc < {1'b0, num_lim};
    assign exp_zero = (exp_q == '0);
    assign mismatch = (alu_result != exp_q) | (alu_zero != exp_zero);
    assign vec_addr = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (num_vec == '0) ? S_DONE : S_FETCH;
            S_FETCH:        state_nxt = S_LOAD;
            S_LOAD:         state_nxt = S_WAIT;
            S_WAIT:         if (wait_cnt == '0) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = more_vec ? S_FETCH : S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_FETCH) || (state == S_LOAD) || (state == S_WAIT) || (state == S_CHECK);
        done = (state == S_DONE);
        pass = (state == S_DONE) && (err_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            num_lim   <= '0;
            wait_cnt  <= '0;
            exp_q     <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            err_valid <= 1'b0;
            err_index <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_cnt   <= '0;
                        err_cnt   <= '0;
                        err_index <= '0;
                        num_lim   <= (num_vec > MAX_VEC) ? MAX_VEC : num_vec;
                        if (num_vec != '0) idx <= '0;
                    end
                end
                S_LOAD: begin
                    {alu_op, alu_a, alu_b, exp_q} <= vec_data;
                    wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - LW'(1);
                end
                S_CHECK: begin
                    if (vec_cnt != '1) vec_cnt <= vec_cnt + (AW+1)'(1);
                    if (mismatch) begin
                        err_valid <= 1'b1;
                        err_index <= idx;
                        if (err_cnt != '1) err_cnt <= err_cnt + (AW+1)'(1);
                    end
                    // Index stays on the last vector rather than wrapping.
                    if (more_vec && (idx != '1)) idx <= idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vector_checker.sv
// Directed bench for alu_vector_checker with a 2-stage behavioural ALU stub and a sync vector ROM.
module tb_alu_vector_checker;

    localparam int DW = 32, OPW = 4, AW = 4, ALU_LAT = 2;
    localparam int VW = OPW + 3*DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW:0]       num_vec = '0;
    logic [AW-1:0]     vec_addr;
    logic [VW-1:0]     vec_data;
    logic [OPW-1:0]    alu_op;
    logic [DW-1:0]     alu_a, alu_b, alu_result;
    logic              alu_zero;
    logic              busy, done, pass, err_valid;
    logic [AW:0]       vec_cnt, err_cnt;
    logic [AW-1:0]     err_index;

    logic [VW-1:0]     rom [16];
    logic [DW-1:0]     r1, r2;
    logic              force_zero_low = 1'b0;
    int                n_assert = 0;
    int                n_fail = 0;
    int                pulses = 0;
    int                lat;

    always #5 clk = ~clk;

    alu_vector_checker #(.DW(DW), .OPW(OPW), .AW(AW), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .vec_addr(vec_addr), .vec_data(vec_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .err_valid(err_valid), .err_index(err_index)
    );

    always @(posedge clk) vec_data <= rom[vec_addr];

    always @(posedge clk) begin
        r1 <= (alu_op == 4'd1) ? (alu_a - alu_b) : (alu_a + alu_b);
        r2 <= r1;
    end
    assign alu_result = r2;
    assign alu_zero   = force_zero_low ? 1'b0 : (r2 == '0);

    always begin
        @(posedge clk);
        #1;
        if (err_valid === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lat = edges after the start-sampling edge until done is seen; -1 on timeout.
    // poke >= 0 pulses start (with num_vec=0) that many edges into the run.
    task automatic run(input logic [AW:0] n, input int poke, output int l);
        pulses = 0;
        @(posedge clk); #1;
        num_vec = n;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = -1;
        for (int i = 0; i <= 200; i++) begin
            if (i == poke) begin start = 1'b1; num_vec = '0; end
            else if (i == poke + 1) start = 1'b0;
            if (done === 1'b1) begin l = i; break; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = {4'd0, 32'd5, 32'd7, 32'hC};
        rom[1] = {4'd1, 32'd9, 32'd9, 32'd0};
        rom[2] = {4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_vec_cnt", vec_cnt, 0);
        check("rst_alu_a", alu_a, 0);

        // Clean three-vector run
        run(5'd3, -1, lat);
        check("clean_latency", lat, 15);
        check("clean_vec_cnt", vec_cnt, 3);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_pass", pass, 1);
        check("clean_pulses", pulses, 0);
        check("clean_busy", busy, 0);
        check("clean_alu_a_hold", alu_a, 32'hFFFF_FFFF);

        // Wrong expected value on vector 1
        rom[1] = {4'd1, 32'd9, 32'd9, 32'd1};
        run(5'd3, -1, lat);
        check("err_latency", lat, 15);
        check("err_pulses", pulses, 1);
        check("err_index", err_index, 1);
        check("err_cnt", err_cnt, 1);
        check("err_pass", pass, 0);
        check("err_vec_cnt", vec_cnt, 3);

        // Zero vectors: done next cycle, address untouched
        check("zero_pre_addr", vec_addr, 2);
        run(5'd0, -1, lat);
        check("zero_latency", lat, 0);
        check("zero_pass", pass, 1);
        check("zero_vec_cnt", vec_cnt, 0);
        check("zero_addr", vec_addr, 2);
        check("zero_err_cnt", err_cnt, 0);

        // Mismatch on zero flag only
        rom[0] = {4'd1, 32'd4, 32'd4, 32'd0};
        force_zero_low = 1'b1;
        run(5'd1, -1, lat);
        force_zero_low = 1'b0;
        check("zflag_latency", lat, 5);
        check("zflag_err_cnt", err_cnt, 1);
        check("zflag_pulses", pulses, 1);
        check("zflag_index", err_index, 0);
        check("zflag_pass", pass, 0);

        // Oversized count clamps to the 16-entry ROM
        rom[0] = {4'd0, 32'd5, 32'd7, 32'hC};
        rom[1] = {4'd1, 32'd9, 32'd9, 32'd0};
        run(5'd31, -1, lat);
        check("clamp_latency", lat, 80);
        check("clamp_vec_cnt", vec_cnt, 16);
        check("clamp_addr", vec_addr, 15);
        check("clamp_pass", pass, 1);

        // Reset in the middle of vector 1's WAIT
        @(posedge clk); #1;
        num_vec = 5'd3;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrst_busy_before", busy, 1);
        check("midrst_addr_before", vec_addr, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_vec_cnt", vec_cnt, 0);
        check("midrst_alu_a", alu_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Restart; a start pulse while busy must be ignored
        run(5'd3, 3, lat);
        check("restart_latency", lat, 15);
        check("restart_vec_cnt", vec_cnt, 3);
        check("restart_pass", pass, 1);
        check("restart_err_cnt", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
